pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline controller for the 5-stage IF/ID/EX/MEM/WB processor datapath.
- Owns run state (idle/run/drain/done), per-stage valid bits and PC/IF-ID enables.
- Owns load-use stall and branch flush generation, plus EX-stage operand forwarding selects.
- Generalises register-address width; adds halt draining and optional performance counters.

Parameters:
REG_AW, 4, register-address width (16 registers at default)
DRAIN_CYC, 3, cycles for a halt in ID to retire through WB
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  begin execution; sampled in IDLE and DONE
halt_req  in  1  ID holds a halt instruction
id_ra1, id_ra2  in  REG_AW  ID source register addresses
id_use1, id_use2  in  1  ID instruction reads ra1/ra2
ex_ra1, ex_ra2  in  REG_AW  EX source register addresses
ex_ra3  in  REG_AW  EX destination
ex_memread, ex_regwrite  in  1  EX control
mem_ra3  in  REG_AW  MEM destination; mem_regwrite in 1
wb_ra3  in  REG_AW  WB destination; wb_regwrite in 1
ex_branch_taken  in  1  branch resolved taken in EX
pc_en  out  1  PC register load enable
if_id_en  out  1  IF/ID register load enable
if_id_flush, id_ex_flush  out  1  clear stage register to bubble
valid  out  5  {wb,mem,ex,id,if} valid bits
fwd_a_sel, fwd_b_sel  out  2  00 regfile, 01 WB, 10 MEM
running, done  out  1  state indicators
cyc_cnt, stall_cnt, flush_cnt  out  CNT_W  performance counters

Behaviour:
- Reset (rst=0, async): state=IDLE; valid=0; pc_en=0; if_id_en=0; flushes=0; fwd selects=00; counters=0; done=0; running=0.
- Reset asserted mid-run aborts immediately; no drain.
- States:
  - IDLE -> RUN when start=1.
  - RUN -> DRAIN when halt_req & valid[1] & !stall & !ex_branch_taken; drain counter loads DRAIN_CYC.
  - DRAIN decrements the counter each cycle; at 0 -> DONE.
  - DONE -> RUN when start=1; counters clear on that transition.
- valid[0]=1 only in RUN; pc_en=(state==RUN) & !stall.
- stall (load-use) = ex_memread & ex_regwrite & valid[2] & valid[1] & ((id_use1 & id_ra1==ex_ra3) | (id_use2 & id_ra2==ex_ra3)).
- On stall: pc_en=0, if_id_en=0, id_ex_flush=1; instruction in ID is held.
- flush = ex_branch_taken & valid[2]: if_id_flush=1, id_ex_flush=1, if_id_en=1 (new target fetched). Flush overrides stall.
- Valid update per cycle:
  - valid[1] <= flush ? 0 : stall ? valid[1] : valid[0].
  - valid[2] <= (flush|stall) ? 0 : valid[1].
  - valid[3] <= valid[2]; valid[4] <= valid[3].
- In DRAIN: valid[0]=0, pc_en=0; in-flight instructions retire normally. A taken branch behind the halt cannot occur, since halt entered EX.
- Forwarding, combinational: fwd_a_sel=10 if valid[3] & mem_regwrite & mem_ra3==ex_ra1; else 01 if valid[4] & wb_regwrite & wb_ra3==ex_ra1; else 00. fwd_b_sel uses the same rule on ex_ra2. MEM has priority over WB.
- running=1 in RUN and DRAIN; done=1 in DONE only.

Optional Feature:
- PIPE_PERF_CNT_EN defined:
  - cyc_cnt increments every RUN/DRAIN cycle.
  - stall_cnt increments per stall cycle.
  - flush_cnt increments per flush cycle.
  - All counters saturate at 2^CNT_W-1 and clear on reset or on a DONE->RUN start.
- PIPE_PERF_CNT_EN undefined: counter ports remain, tied to 0; no counter flops.

Test Plan:
- Reset, then start pulse -> valid = 00001, 00011, 00111, 01111, 11111 on successive cycles; pc_en=1; running=1.
- EX lw r3 (ex_memread=1, ex_ra3=3), ID uses r3 via id_ra1 -> exactly one cycle pc_en=0, if_id_en=0, id_ex_flush=1; valid[2]=0 next cycle.
- ex_ra1=5, mem_ra3=5, wb_ra3=5, both regwrite -> fwd_a_sel=10; drop mem_regwrite -> 01; drop wb_regwrite -> 00.
- ex_branch_taken=1 coinciding with a load-use stall -> if_id_flush=1, id_ex_flush=1, if_id_en=1; next cycle valid[1]=0, valid[2]=0.
- halt_req in ID during RUN -> pc_en=0 next cycle, running=1 for 3 cycles, then done=1; rst=0 during DRAIN -> all outputs 0 immediately.
- With PIPE_PERF_CNT_EN, 10 RUN cycles, 1 stall, 1 flush -> cyc_cnt=10, stall_cnt=1, flush_cnt=1; without the macro all three read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-controller bundle: run/hazard inputs from the datapath, enables, flushes and status back.
// master = controller side, slave = datapath side.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              halt_req;
    logic [REG_AW-1:0] id_ra1;
    logic [REG_AW-1:0] id_ra2;
    logic              id_use1;
    logic              id_use2;
    logic [REG_AW-1:0] ex_ra1;
    logic [REG_AW-1:0] ex_ra2;
    logic [REG_AW-1:0] ex_ra3;
    logic              ex_memread;
    logic              ex_regwrite;
    logic [REG_AW-1:0] mem_ra3;
    logic              mem_regwrite;
    logic [REG_AW-1:0] wb_ra3;
    logic              wb_regwrite;
    logic              ex_branch_taken;

    logic              pc_en;
    logic              if_id_en;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic [4:0]        valid;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              running;
    logic              done;
    logic [CNT_W-1:0]  cyc_cnt;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        input  start, halt_req, id_ra1, id_ra2, id_use1, id_use2,
               ex_ra1, ex_ra2, ex_ra3, ex_memread, ex_regwrite,
               mem_ra3, mem_regwrite, wb_ra3, wb_regwrite, ex_branch_taken,
        output pc_en, if_id_en, if_id_flush, id_ex_flush, valid,
               fwd_a_sel, fwd_b_sel, running, done,
               cyc_cnt, stall_cnt, flush_cnt
    );

    modport slave (
        output start, halt_req, id_ra1, id_ra2, id_use1, id_use2,
               ex_ra1, ex_ra2, ex_ra3, ex_memread, ex_regwrite,
               mem_ra3, mem_regwrite, wb_ra3, wb_regwrite, ex_branch_taken,
        input  pc_en, if_id_en, if_id_flush, id_ex_flush, valid,
               fwd_a_sel, fwd_b_sel, running, done,
               cyc_cnt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline controller: run state, stage valids, load-use stall, branch flush, EX forwarding.
// Define PIPE_PERF_CNT_EN to build the cycle/stall/flush performance counters; otherwise they read 0.
module pipe_hazard_ctrl #(
    parameter int REG_AW    = 4,
    parameter int DRAIN_CYC = 3,
    parameter int CNT_W     = 16
) (
    input logic                clk,
    input logic                rst,
    pipe_hazard_ctrl_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam int DW = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

    state_t        state, state_nx;
    logic [DW-1:0] drain_cnt, drain_cnt_nx;
    logic [4:1]    vq;
    logic          is_run;
    logic          active;
    logic          stall;
    logic          flush;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic              mem_v,
        input logic              mem_we,
        input logic [REG_AW-1:0] mem_rd,
        input logic              wb_v,
        input logic              wb_we,
        input logic [REG_AW-1:0] wb_rd
    );
        if (mem_v && mem_we && (mem_rd == src))
            return 2'b10;
        else if (wb_v && wb_we && (wb_rd == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        is_run = (state == S_RUN);
        active = is_run || (state == S_DRAIN);
        stall  = bus.ex_memread & bus.ex_regwrite & vq[2] & vq[1] &
                 ((bus.id_use1 & (bus.id_ra1 == bus.ex_ra3)) |
                  (bus.id_use2 & (bus.id_ra2 == bus.ex_ra3)));
        flush  = bus.ex_branch_taken & vq[2];
    end

    // A taken branch redirects fetch even when a load-use stall is pending.
    always_comb begin
        bus.valid       = {vq, is_run};
        bus.pc_en       = is_run & (flush | ~stall);
        bus.if_id_en    = is_run & (flush | ~stall);
        bus.if_id_flush = flush;
        bus.id_ex_flush = flush | stall;
        bus.fwd_a_sel   = fwd_sel(bus.ex_ra1, vq[3], bus.mem_regwrite, bus.mem_ra3,
                                  vq[4], bus.wb_regwrite, bus.wb_ra3);
        bus.fwd_b_sel   = fwd_sel(bus.ex_ra2, vq[3], bus.mem_regwrite, bus.mem_ra3,
                                  vq[4], bus.wb_regwrite, bus.wb_ra3);
        bus.running     = active;
        bus.done        = (state == S_DONE);
    end

    // DONE is taken on the cycle the counter would reach zero, so DRAIN lasts DRAIN_CYC cycles.
    always_comb begin
        state_nx     = state;
        drain_cnt_nx = drain_cnt;
        case (state)
            S_IDLE: begin
                if (bus.start)
                    state_nx = S_RUN;
            end
            S_RUN: begin
                if (bus.halt_req && vq[1] && !stall && !bus.ex_branch_taken) begin
                    state_nx     = S_DRAIN;
                    drain_cnt_nx = DW'(DRAIN_CYC);
                end
            end
            S_DRAIN: begin
                if (drain_cnt <= DW'(1)) begin
                    state_nx     = S_DONE;
                    drain_cnt_nx = '0;
                end else begin
                    drain_cnt_nx = drain_cnt - DW'(1);
                end
            end
            S_DONE: begin
                if (bus.start)
                    state_nx = S_RUN;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_nx;
            drain_cnt <= drain_cnt_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vq <= '0;
        end else begin
            vq[1] <= flush ? 1'b0 : (stall ? vq[1] : is_run);
            vq[2] <= (flush | stall) ? 1'b0 : vq[1];
            vq[3] <= vq[2];
            vq[4] <= vq[3];
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic             restart;
    logic [CNT_W-1:0] cyc_q, stall_q, flush_q;

    assign restart = (state == S_DONE) && bus.start;

    // Stall cycles overridden by a flush are counted as flushes only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else if (restart) begin
            cyc_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (active && (cyc_q != '1))
                cyc_q <= cyc_q + CNT_W'(1);
            if (stall && !flush && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
            if (flush && (flush_q != '1))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign bus.cyc_cnt   = cyc_q;
    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
`else
    assign bus.cyc_cnt   = {CNT_W{1'b0}};
    assign bus.stall_cnt = {CNT_W{1'b0}};
    assign bus.flush_cnt = {CNT_W{1'b0}};
`endif
endmodule
